fetch_sequencer: RTL and testbench

Sequences instruction fetch from the single-port, combinational-read instruction memory (256 x 32-bit, word-addressed) and presents one instruction at a time to decode over a valid/ready handshake. It owns the program counter, accepts branch redirects from execute, and detects HALT (opcode nibble instr[31:28] = 4'h6) to stop fetching. It sits between instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, feeds decode over valid/ready, stops on HALT or out-of-range PC.
// Optional build macro HALT_RESUME_EN lets a redirect restart fetching from the HALTED state.
module fetch_sequencer #(
  parameter int                PC_W        = 32,
  parameter int                MEM_DEPTH   = 256,
  parameter logic [PC_W-1:0]   RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'h6,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [PC_W-1:0]   if_pc,
  input  logic              if_ready,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted,
  output logic              oob_err,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  // One extra bit so MEM_DEPTH itself is representable even when it equals 2^PC_W.
  localparam logic [PC_W:0] DEPTH_EXT = (PC_W+1)'(MEM_DEPTH);

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_if_valid;
  logic [31:0]      r_if_instr;
  logic [PC_W-1:0]  r_if_pc;
  logic             r_halted;
  logic             r_oob_err;
  logic [CNT_W-1:0] r_fetch_count;

  state_t           w_state_next;
  logic [PC_W-1:0]  w_pc_next;
  logic             w_if_valid_next;
  logic [31:0]      w_if_instr_next;
  logic [PC_W-1:0]  w_if_pc_next;
  logic             w_halted_next;
  logic             w_oob_err_next;
  logic [CNT_W-1:0] w_fetch_count_next;

  logic w_free;
  logic w_accept;
  logic w_pc_in_range;
  logic w_is_halt;

  assign w_free        = !r_if_valid || if_ready;
  assign w_accept      = r_if_valid && if_ready;
  assign w_pc_in_range = ({1'b0, r_pc} < DEPTH_EXT);
  assign w_is_halt     = (imem_rdata[31:28] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_halted      <= 1'b0;
      r_oob_err     <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_if_valid    <= w_if_valid_next;
      r_if_instr    <= w_if_instr_next;
      r_if_pc       <= w_if_pc_next;
      r_halted      <= w_halted_next;
      r_oob_err     <= w_oob_err_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_if_valid_next    = r_if_valid;
    w_if_instr_next    = r_if_instr;
    w_if_pc_next       = r_if_pc;
    w_halted_next      = r_halted;
    w_oob_err_next     = r_oob_err;
    w_fetch_count_next = r_fetch_count;

    // A completed handshake always counts, even on an edge that also redirects.
    if (w_accept) begin
      w_if_valid_next = 1'b0;
      if (r_fetch_count != {CNT_W{1'b1}}) begin
        w_fetch_count_next = r_fetch_count + CNT_W'(1);
      end
    end

    case (r_state)
      ST_FETCH: begin
        if (redirect_valid) begin
          w_pc_next       = redirect_pc;
          w_if_valid_next = 1'b0;
        end else if (w_free) begin
          if (w_pc_in_range) begin
            w_if_instr_next = imem_rdata;
            w_if_pc_next    = r_pc;
            w_if_valid_next = 1'b1;
            if (w_is_halt) begin
              w_state_next  = ST_HALTED;
              w_halted_next = 1'b1;
            end else begin
              w_pc_next = r_pc + PC_W'(1);
            end
          end else begin
            w_state_next   = ST_ERROR;
            w_oob_err_next = 1'b1;
          end
        end
      end
      ST_HALTED: begin
`ifdef HALT_RESUME_EN
        if (redirect_valid) begin
          w_state_next    = ST_FETCH;
          w_halted_next   = 1'b0;
          w_pc_next       = redirect_pc;
          w_if_valid_next = 1'b0;
        end
`endif
      end
      ST_ERROR: begin
      end
      default: begin
        w_state_next = ST_ERROR;
      end
    endcase
  end

  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign halted      = r_halted;
  assign oob_err     = r_oob_err;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed program scenarios plus randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        oob_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0 = fetching, 1 = halted, 2 = error.
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  bit          m_halted;
  bit          m_oob;
  int          m_count;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .oob_err        (oob_err),
    .fetch_count    (fetch_count)
  );

  assign imem_rdata = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_pc     = 32'd0;
    m_valid  = 0;
    m_instr  = 32'd0;
    m_ipc    = 32'd0;
    m_halted = 0;
    m_oob    = 0;
    m_count  = 0;
  endtask

  task automatic model_step();
    bit          slot_free;
    logic [31:0] word;
    slot_free = !m_valid || if_ready;
    if (m_valid && if_ready) begin
      if (m_count < 65535) m_count++;
      m_valid = 0;
      $display("xfer: pc=%0d instr=%08h count=%0d", m_ipc, m_instr, m_count);
    end
    if (m_mode == 0) begin
      if (redirect_valid) begin
        m_pc    = redirect_pc;
        m_valid = 0;
      end else if (slot_free) begin
        if (m_pc < 32'd256) begin
          word    = mem[m_pc[7:0]];
          m_instr = word;
          m_ipc   = m_pc;
          m_valid = 1;
          if (word[31:28] == 4'h6) begin
            m_mode   = 1;
            m_halted = 1;
          end else begin
            m_pc = m_pc + 32'd1;
          end
        end else begin
          m_mode = 2;
          m_oob  = 1;
        end
      end
    end
`ifdef HALT_RESUME_EN
    else if (m_mode == 1 && redirect_valid) begin
      m_mode   = 0;
      m_halted = 0;
      m_pc     = redirect_pc;
      m_valid  = 0;
    end
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("if_valid", if_valid, m_valid);
    chk("halted", halted, m_halted);
    chk("oob_err", oob_err, m_oob);
    chk("fetch_count", fetch_count, m_count);
    chk("imem_addr", imem_addr, m_pc);
    if (m_valid) begin
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ipc);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
  endtask

  task automatic load_straight();
    fill_linear();
    mem[0] = 32'h22000017;
    mem[1] = 32'h26200017;
    mem[2] = 32'h42020003;
    mem[3] = 32'h60000004;
  endtask

  // Called at a falling edge: asserts reset mid-cycle, checks outputs drop at once, releases on the next falling edge.
  task automatic apply_reset();
    #3;
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #1;
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_oob", oob_err, 1'b0);
    chk("rst_count", fetch_count, 16'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    load_straight();
    repeat (2) @(negedge clk);

    // Straight-line program with decode always ready
    apply_reset();
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sl_valid", if_valid, 1'b1);
      chk("sl_pc", if_pc, i);
    end
    chk("sl_halt_instr", if_instr, 32'h60000004);
    chk("sl_halted", halted, 1'b1);
    tick();
    chk("sl_count", fetch_count, 16'd4);
    chk("sl_drained", if_valid, 1'b0);
    tick();
    tick();
    chk("sl_no_more", if_valid, 1'b0);

    // Backpressure holds the second instruction stable
    apply_reset();
    if_ready = 1'b1;
    tick();
    tick();
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_pc", if_pc, 32'd1);
      chk("bp_hold_instr", if_instr, 32'h26200017);
    end
    if_ready = 1'b1;
    tick();
    chk("bp_resume_pc", if_pc, 32'd2);
    tick();
    chk("bp_next_pc", if_pc, 32'd3);
    tick();
    chk("bp_count", fetch_count, 16'd4);

    // Redirect flushes a held instruction
    fill_linear();
    apply_reset();
    if_ready = 1'b1;
    tick();
    tick();
    if_ready = 1'b0;
    tick();
    chk("rd_pre_addr", imem_addr, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd7;
    tick();
    chk("rd_flushed", if_valid, 1'b0);
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    tick();
    chk("rd_target_pc", if_pc, 32'd7);
    chk("rd_count", fetch_count, 16'd1);

    // Last valid word, then out of range; later redirect ignored
    apply_reset();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd255;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("oob_last_pc", if_pc, 32'd255);
    chk("oob_not_yet", oob_err, 1'b0);
    tick();
    chk("oob_set", oob_err, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("oob_ignored_addr", imem_addr, 32'd256);
    chk("oob_no_valid", if_valid, 1'b0);

    // Direct redirect to 256
    apply_reset();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd256;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("oob256_set", oob_err, 1'b1);
    chk("oob256_valid", if_valid, 1'b0);

    // Reset asserted while backpressured at pc=5
    apply_reset();
    if_ready = 1'b1;
    repeat (5) tick();
    if_ready = 1'b0;
    tick();
    chk("mid_addr", imem_addr, 32'd5);
    apply_reset();
    if_ready = 1'b1;
    tick();
    chk("mid_first_pc", if_pc, 32'd0);
    chk("mid_first_valid", if_valid, 1'b1);

    // Redirect while halted
    load_straight();
    apply_reset();
    if_ready = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd1;
    tick();
    redirect_valid = 1'b0;
    tick();
`ifdef HALT_RESUME_EN
    chk("hr_halted", halted, 1'b0);
    chk("hr_pc", if_pc, 32'd1);
    chk("hr_valid", if_valid, 1'b1);
`else
    chk("hr_halted", halted, 1'b1);
    chk("hr_valid", if_valid, 1'b0);
`endif

    // Randomized episodes
    for (int ep = 0; ep < 10; ep++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = $urandom;
        if ($urandom_range(0, 39) == 0) mem[i][31:28] = 4'h6;
        else if (mem[i][31:28] == 4'h6) mem[i][31:28] = 4'h7;
      end
      apply_reset();
      for (int c = 0; c < 250; c++) begin
        if_ready       = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 3) == 0) redirect_pc = $urandom_range(250, 260);
        else                           redirect_pc = $urandom_range(0, 255);
        tick();
      end
    end

    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
